// File: rtl/wb_arbiter_pkg.sv
// Shared sizes and types for the write-port arbiter: four requesters
// funnel register writes into a single one-entry write stage.
package wb_arbiter_pkg;

    localparam int NUM_REQ    = 4;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_W     = 16;
    localparam int REG_COUNT  = 16;
    localparam int PTR_W      = $clog2(NUM_REQ);

    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } stage_t;

endpackage : wb_arbiter_pkg

// File: rtl/decoder4_16.sv
// Library 4-to-16 one-hot decoder.
module decoder4_16 (
    input  logic [3:0]  sel,
    output logic [15:0] dec
);

    always_comb begin
        dec = 16'h0001 << sel;
    end

endmodule : decoder4_16

// File: rtl/wb_arbiter.sv
// Round-robin arbiter feeding a single-entry register-file write stage.
// The stage drains one write per cycle unless the write port is held.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int R0_WRITABLE = 1
) (
    input  logic                          I_CLK,
    input  logic                          I_NRESET,
    input  logic [NUM_REQ-1:0]            I_REQ_VALID,
    input  logic [NUM_REQ*REG_ADDR_W-1:0] I_REQ_ADDR,
    input  logic [NUM_REQ*DATA_W-1:0]     I_REQ_DATA,
    output logic [NUM_REQ-1:0]            O_REQ_READY,
    input  logic                          I_HOLD,
    output logic [REG_COUNT-1:0]          O_WR_EN,
    output logic [REG_ADDR_W-1:0]         O_WR_ADDR,
    output logic [DATA_W-1:0]             O_WR_DATA,
    output logic [REG_COUNT-1:0]          O_BUSY
);

    // Handshake: a requester presents VALID with stable-at-transfer ADDR/DATA;
    // the transfer happens in the cycle where VALID[n] & READY[n]. VALID may
    // be withdrawn before READY without effect, and READY never depends on
    // a requester other than through the round-robin search.

    function automatic logic [NUM_REQ-1:0] rr_grant(
        input logic [NUM_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr
    );
        logic [NUM_REQ-1:0] grant;
        logic [PTR_W-1:0]   idx;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + PTR_W'(i);
            if (valid[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

    logic [PTR_W-1:0]      ptr;
    stage_t                stg;
    logic                  accept;
    logic                  commit;
    logic                  xfer;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]     sel_data;
    logic [REG_COUNT-1:0]  stg_onehot;
    logic                  wr_allowed;

    assign accept = !stg.v || !I_HOLD;
    assign commit = stg.v && !I_HOLD;

    // Grant is also masked by reset so READY is quiet while held in reset.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        if (I_NRESET && accept) begin
            grant = rr_grant(I_REQ_VALID, ptr);
        end
        for (int n = 0; n < NUM_REQ; n++) begin
            if (grant[n]) begin
                grant_idx = PTR_W'(n);
                sel_addr  = I_REQ_ADDR[n*REG_ADDR_W +: REG_ADDR_W];
                sel_data  = I_REQ_DATA[n*DATA_W +: DATA_W];
            end
        end
    end

    assign xfer        = |grant;
    assign O_REQ_READY = grant;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            ptr <= '0;
            stg <= '0;
        end else if (xfer) begin
            ptr      <= grant_idx + PTR_W'(1);
            stg.v    <= 1'b1;
            stg.addr <= sel_addr;
            stg.data <= sel_data;
        end else if (commit) begin
            stg.v <= 1'b0;
        end
    end

    decoder4_16 u_dec (
        .sel (stg.addr),
        .dec (stg_onehot)
    );

    // With r0 read-only the entry still drains; only the enable is dropped.
    assign wr_allowed = (R0_WRITABLE != 0) || (stg.addr != '0);

    assign O_WR_EN   = (commit && wr_allowed) ? stg_onehot : '0;
    assign O_BUSY    = stg.v ? stg_onehot : '0;
    assign O_WR_ADDR = stg.addr;
    assign O_WR_DATA = stg.data;

endmodule : wb_arbiter

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one default instance and one with r0
// read-only, both driven by the same stimulus.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic        hold;

    logic [3:0]  req_ready, req_ready_r0;
    logic [15:0] wr_en, wr_en_r0;
    logic [3:0]  wr_addr, wr_addr_r0;
    logic [15:0] wr_data, wr_data_r0;
    logic [15:0] busy, busy_r0;

    int checks;
    int passes;

    wb_arbiter dut (
        .I_CLK       (clk),
        .I_NRESET    (rst_n),
        .I_REQ_VALID (req_valid),
        .I_REQ_ADDR  (req_addr),
        .I_REQ_DATA  (req_data),
        .O_REQ_READY (req_ready),
        .I_HOLD      (hold),
        .O_WR_EN     (wr_en),
        .O_WR_ADDR   (wr_addr),
        .O_WR_DATA   (wr_data),
        .O_BUSY      (busy)
    );

    wb_arbiter #(.R0_WRITABLE(0)) dut_r0 (
        .I_CLK       (clk),
        .I_NRESET    (rst_n),
        .I_REQ_VALID (req_valid),
        .I_REQ_ADDR  (req_addr),
        .I_REQ_DATA  (req_data),
        .O_REQ_READY (req_ready_r0),
        .I_HOLD      (hold),
        .O_WR_EN     (wr_en_r0),
        .O_WR_ADDR   (wr_addr_r0),
        .O_WR_DATA   (wr_data_r0),
        .O_BUSY      (busy_r0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change just after the rising edge; checks run at the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic [15:0] fair_ready [0:7];
    logic [15:0] fair_wren  [0:7];

    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = 4'hF;
        req_addr  = 16'h0000;
        req_data  = 64'h0;

        fair_ready = '{16'h1, 16'h2, 16'h4, 16'h8, 16'h1, 16'h2, 16'h4, 16'h8};
        fair_wren  = '{16'h0010, 16'h0002, 16'h0004, 16'h0008,
                       16'h0010, 16'h0002, 16'h0004, 16'h0008};

        // Reset: everything quiet even with all requesters asserting.
        settle();
        chk("rst_ready", 16'(req_ready), 16'h0);
        chk("rst_wren", wr_en, 16'h0);
        chk("rst_busy", busy, 16'h0);
        chk("rst_wdata", wr_data, 16'h0);
        chk("rst_waddr", 16'(wr_addr), 16'h0);

        // Single request from requester 2 to r5.
        next_cycle();
        rst_n     = 1'b1;
        req_valid = 4'b0100;
        req_addr  = 16'h0500;
        req_data  = 64'h0000_BEEF_0000_0000;
        settle();
        chk("single_ready", 16'(req_ready), 16'h0004);
        chk("single_wren_n", wr_en, 16'h0);
        next_cycle();
        req_valid = 4'b0000;
        settle();
        chk("single_wren", wr_en, 16'h0020);
        chk("single_wdata", wr_data, 16'hBEEF);
        chk("single_waddr", 16'(wr_addr), 16'h0005);
        chk("single_busy", busy, 16'h0020);
        next_cycle();
        settle();
        chk("drain_busy", busy, 16'h0);
        chk("drain_wren", wr_en, 16'h0);
        chk("retain_wdata", wr_data, 16'hBEEF);

        // Move the pointer to 0 by granting requester 3 (addresses r1..r4).
        next_cycle();
        req_valid = 4'b1000;
        req_addr  = 16'h4321;
        req_data  = 64'hD003_D002_D001_D000;
        settle();
        chk("align_ready", 16'(req_ready), 16'h0008);

        // Fairness: all valid for 8 cycles.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            req_valid = 4'hF;
            settle();
            chk($sformatf("fair_ready%0d", k), 16'(req_ready), fair_ready[k]);
            chk($sformatf("fair_wren%0d", k), wr_en, fair_wren[k]);
        end

        // Hold with r7 in the stage.
        next_cycle();
        req_valid = 4'b0001;
        req_addr  = 16'h4327;
        req_data  = 64'hD003_D002_D001_7777;
        settle();
        chk("r7_ready", 16'(req_ready), 16'h0001);
        chk("r7_prev_wren", wr_en, 16'h0010);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            hold     = 1'b1;
            req_addr = 16'h4329;
            req_data = 64'hD003_D002_D001_1234;
            settle();
            chk($sformatf("hold_ready%0d", k), 16'(req_ready), 16'h0);
            chk($sformatf("hold_wren%0d", k), wr_en, 16'h0);
            chk($sformatf("hold_busy%0d", k), busy, 16'h0080);
            chk($sformatf("hold_wdata%0d", k), wr_data, 16'h7777);
        end
        next_cycle();
        hold = 1'b0;
        settle();
        chk("release_wren", wr_en, 16'h0080);
        chk("release_ready", 16'(req_ready), 16'h0001);
        next_cycle();
        req_valid = 4'b0000;
        settle();
        chk("b2b_wren", wr_en, 16'h0200);
        chk("b2b_wdata", wr_data, 16'h1234);

        // Hold with an empty stage: one grant fills it, then it waits.
        next_cycle();
        hold      = 1'b1;
        req_valid = 4'b0010;
        req_addr  = 16'h4369;
        settle();
        chk("hfill_ready", 16'(req_ready), 16'h0002);
        chk("hfill_busy0", busy, 16'h0);
        next_cycle();
        settle();
        chk("hfill_ready2", 16'(req_ready), 16'h0);
        chk("hfill_busy", busy, 16'h0040);
        chk("hfill_wren", wr_en, 16'h0);
        next_cycle();
        hold      = 1'b0;
        req_valid = 4'b0000;
        settle();
        chk("hfill_commit", wr_en, 16'h0040);

        // r0 write: suppressed only on the read-only instance.
        next_cycle();
        req_valid = 4'b0001;
        req_addr  = 16'h4360;
        req_data  = 64'hD003_D002_D001_0ABC;
        settle();
        chk("r0_ready", 16'(req_ready_r0), 16'h0001);
        next_cycle();
        req_valid = 4'b0000;
        settle();
        chk("r0_wren_ro", wr_en_r0, 16'h0);
        chk("r0_busy_ro", busy_r0, 16'h0001);
        chk("r0_wren_rw", wr_en, 16'h0001);
        next_cycle();
        settle();
        chk("r0_empty_ro", busy_r0, 16'h0);

        // Reset mid-flight: pointer is 1, so requester 2 wins with r3.
        next_cycle();
        req_valid = 4'b0101;
        req_addr  = 16'h0301;
        settle();
        chk("mid_ready", 16'(req_ready), 16'h0004);
        next_cycle();
        req_valid = 4'b0000;
        rst_n     = 1'b0;
        settle();
        chk("mid_wren", wr_en, 16'h0);
        chk("mid_busy", busy, 16'h0);
        chk("mid_waddr", 16'(wr_addr), 16'h0);
        next_cycle();
        settle();
        chk("mid_wren2", wr_en, 16'h0);
        next_cycle();
        rst_n     = 1'b1;
        req_valid = 4'hF;
        req_addr  = 16'h4321;
        settle();
        chk("post_rst_ready", 16'(req_ready), 16'h0001);
        next_cycle();
        req_valid = 4'b0000;
        settle();
        chk("post_rst_wren", wr_en, 16'h0002);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_wb_arbiter

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter R0_WRITABLE, default 1, meaning: 0 = writes to r0 are accepted but never reach the write port.
REQ-002 I_CLK  input  1  single clock; all state updates on rising edge.
REQ-003 I_NRESET  input  1  reset is asynchronous and active-low.
REQ-004 I_REQ_VALID  input  4  per-requester write request; bit n = requester n.
REQ-005 I_REQ_ADDR  input  16  packed destination register indices, requester n at [4n+3:4n].
REQ-006 I_REQ_DATA  input  64  packed write data, requester n at [16n+15:16n].
REQ-007 O_REQ_READY  output  4  grant, at most one bit set; transfer = VALID[n] & READY[n] in the same cycle.
REQ-008 I_HOLD  input  1  freeze the write stage (register-file port unavailable).
REQ-009 O_WR_EN  output  16  one-hot register write enable, all-zero when no commit.
REQ-010 O_WR_ADDR  output  4  stage register index.
REQ-011 O_WR_DATA  output  16  stage write data.
REQ-012 O_BUSY  output  16  one-hot mask of the register held in the stage, all-zero when stage empty.

Function
REQ-013 State: 2-bit round-robin pointer PTR, one stage entry {STG_V, STG_ADDR[3:0], STG_DATA[15:0]}.
REQ-014 ACCEPT = !STG_V | !I_HOLD; no grant when ACCEPT = 0.
REQ-015 When ACCEPT = 1, the grant goes to the first valid requester searched PTR, PTR+1, PTR+2, PTR+3 (mod 4); O_REQ_READY is combinational from I_REQ_VALID, PTR, STG_V, I_HOLD.
REQ-016 On a transfer from requester n: PTR <= (n+1) mod 4, stage loads {1, ADDR[n], DATA[n]} at the next edge.
REQ-017 No transfer: PTR unchanged.
REQ-018 Commit cycle = STG_V & !I_HOLD; O_WR_EN = one-hot(STG_ADDR) in a commit cycle, else 16'h0000.
REQ-019 At the edge ending a commit cycle, STG_V <= 0 unless a transfer occurs in the same cycle (back-to-back: new entry replaces committed one, 1 write per cycle sustained).
REQ-020 Latency: transfer in cycle N -> O_WR_EN asserted in cycle N+1 when I_HOLD = 0 in N+1.
REQ-021 I_HOLD = 1 with STG_V = 1: stage, PTR and outputs frozen, O_REQ_READY = 0, O_WR_EN = 0.
REQ-022 I_HOLD = 1 with STG_V = 0: one grant allowed to fill the stage; entry then waits for I_HOLD = 0.
REQ-023 O_WR_ADDR/O_WR_DATA always reflect STG_ADDR/STG_DATA; retain last value when stage empty.
REQ-024 O_BUSY = one-hot(STG_ADDR) whenever STG_V = 1, independent of I_HOLD.
REQ-025 R0_WRITABLE = 0 and STG_ADDR = 0: O_WR_EN = 0 in the commit cycle; entry still drains, O_BUSY bit 0 still reported.
REQ-026 Requester dropping VALID before READY: legal, no state change; ADDR/DATA sampled only at transfer.
REQ-027 All four requesters valid continuously, I_HOLD = 0: grants rotate 0,1,2,3,0,... one per cycle.

Reset
REQ-028 I_NRESET low asynchronously forces PTR = 0, STG_V = 0, STG_ADDR = 0, STG_DATA = 0; hence O_WR_EN = 0, O_BUSY = 0, O_WR_ADDR = 0, O_WR_DATA = 0, O_REQ_READY = 0 while low.
REQ-029 Reset mid-operation drops any in-flight stage entry with no write; first grant after release starts search at requester 0.

Structure
REQ-030 Shared package holds NUM_REQ = 4, REG_ADDR_W = 4, DATA_W = 16, REG_COUNT = 16.
REQ-031 One-hot generation for O_WR_EN and O_BUSY reuses the existing decoder4_16 library module (one instance on STG_ADDR, outputs gated).
REQ-032 Round-robin priority search is a combinational function inside wb_arbiter; no further sub-modules.

Verification
REQ-033 Single request: VALID=4'b0100, ADDR[2]=4'd5, DATA[2]=16'hBEEF -> READY=4'b0100 cycle N; cycle N+1 O_WR_EN=16'h0020, O_WR_DATA=16'hBEEF, O_BUSY=16'h0020.
REQ-034 Fairness: VALID=4'hF held 8 cycles, I_HOLD=0 -> grant order 0,1,2,3,0,1,2,3; exactly one READY bit per cycle.
REQ-035 Hold: stage holds r7, I_HOLD=1 for 3 cycles with VALID=4'b0001 -> READY=0, O_WR_EN=0, O_BUSY=16'h0080 each cycle; I_HOLD drop -> O_WR_EN=16'h0080 and requester 0 granted same cycle.
REQ-036 R0 suppression: R0_WRITABLE=0, request ADDR=0 -> next cycle O_WR_EN=16'h0000, O_BUSY=16'h0001, stage empties following cycle.
REQ-037 Reset mid-flight: transfer to r3 in cycle N, I_NRESET low in N+1 before edge -> O_WR_EN stays 0, O_BUSY=0; after release VALID=4'hF -> requester 0 granted first.
